vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 92 +++++++++
 tb/tb_vga_sync_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-rate divider, h/v position counters, registered syncs aligned with pix_x/pix_y.
// Define VGA_SYNC_FRAME_TICK_EN to enable the one-clk end-of-frame pulse on frame_tick.
module vga_sync_gen #(
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HR = 96,
    parameter int HB = 48,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VR = 2,
    parameter int VB = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_tick
);

    localparam logic [9:0] H_MAX        = 10'(HD + HF + HR + HB - 1);
    localparam logic [9:0] V_MAX        = 10'(VD + VF + VR + VB - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(HD + HF);
    localparam logic [9:0] H_SYNC_LAST  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(VD + VF);
    localparam logic [9:0] V_SYNC_LAST  = 10'(VD + VF + VR - 1);

    logic       tick_q;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_next, v_next;
    logic       hsync_q, vsync_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick_q) begin
            if (h_cnt == H_MAX) begin
                h_next = '0;
                v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next count so the registered values line up with the counters.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            tick_q  <= ~tick_q;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync_q <= !((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
            vsync_q <= !((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    logic frame_q;

    // Fires on the clk where pixel_tick is high at the last position, i.e. the next tick wraps the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= !tick_q && (h_next == H_MAX) && (v_next == V_MAX);
        end
    end

    assign frame_tick = frame_q;
`else
    assign frame_tick = 1'b0;
`endif

    assign pixel_tick = tick_q;
    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = (h_cnt < 10'(HD)) && (v_cnt < 10'(VD));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: directed vector table, line/frame scans, and randomized resets vs an arithmetic model.
module tb_vga_sync_gen;

    typedef struct {
        int hd, hf, hr, hb, vd, vf, vr, vb;
    } geom_t;

    typedef struct {
        int         clks;   // clks since reset edge
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       hs;
        logic       vid;
    } vec_t;

    localparam geom_t G_BIG   = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t G_SMALL = '{8, 2, 3, 2, 4, 1, 2, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_hs, b_vs, b_vid, b_tick, b_ft;
    logic [9:0] b_x, b_y;
    logic       s_hs, s_vs, s_vid, s_tick, s_ft;
    logic [9:0] s_x, s_y;

    int tests  = 0;
    int failed = 0;
    int n      = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_big (
        .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
        .pixel_tick(b_tick), .pix_x(b_x), .pix_y(b_y), .frame_tick(b_ft)
    );

    vga_sync_gen #(.HD(8), .HF(2), .HR(3), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1)) dut_small (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
        .pixel_tick(s_tick), .pix_x(s_x), .pix_y(s_y), .frame_tick(s_ft)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (clk %0d since reset)", name, act, exp, n);
        end
    endtask

    // Position derives purely from elapsed pixel ticks since reset.
    function automatic logic [31:0] model(input geom_t g, input int clks);
        int ht, vt, t, x, y;
        logic tk, hs, vs, vid, ft;
        ht  = g.hd + g.hf + g.hr + g.hb;
        vt  = g.vd + g.vf + g.vr + g.vb;
        t   = clks / 2;
        x   = t % ht;
        y   = (t / ht) % vt;
        tk  = (clks % 2) == 1;
        hs  = !(x >= g.hd + g.hf && x < g.hd + g.hf + g.hr);
        vs  = !(y >= g.vd + g.vf && y < g.vd + g.vf + g.vr);
        vid = (x < g.hd) && (y < g.vd);
`ifdef VGA_SYNC_FRAME_TICK_EN
        ft  = tk && (x == ht - 1) && (y == vt - 1);
`else
        ft  = 1'b0;
`endif
        return {7'd0, 10'(x), 10'(y), tk, hs, vs, vid, ft};
    endfunction

    function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y, input logic tk,
                                         input logic hs, input logic vs, input logic vid, input logic ft);
        return {7'd0, x, y, tk, hs, vs, vid, ft};
    endfunction

    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else n++;
    endtask

    task automatic check_models(input string tag);
        check({tag, "_big"}, pack(b_x, b_y, b_tick, b_hs, b_vs, b_vid, b_ft), model(G_BIG, n));
        check({tag, "_small"}, pack(s_x, s_y, s_tick, s_hs, s_vs, s_vid, s_ft), model(G_SMALL, n));
    endtask

    vec_t vecs[13];
    int   hs_low, hs_bad, vid_bad, vs_low, vs_bad, ft_cnt;

    initial begin
        vecs[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{4,    10'd2,   10'd0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1503, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1504, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1};

        // Reset state, including video_on reading 1 while reset is held.
        reset = 1'b1;
        step();
        step();
        check("reset_state", pack(b_x, b_y, b_tick, b_hs, b_vs, b_vid, b_ft),
              pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));

        // Directed table on the default-geometry instance.
        reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            while (n < vecs[i].clks) step();
            check($sformatf("vec%0d", i), {b_x, b_y, b_tick, b_hs, b_vid, b_vs},
                  {vecs[i].x, vecs[i].y, vecs[i].tick, vecs[i].hs, vecs[i].vid, 1'b1});
        end

        // Mid-line reset at (300,1), then restart timing.
        while (n < 2200) step();
        check("pre_reset_pos", {22'd0, b_x}, {22'd0, 10'd300});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midframe_reset", pack(b_x, b_y, b_tick, b_hs, b_vs, b_vid, b_ft),
              pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        check("restart_tick1", {b_tick, b_x}, {1'b1, 10'd0});
        step();
        check("restart_tick2", {b_tick, b_x}, {1'b0, 10'd1});

        // One full line on the default geometry: sync width and blanking.
        reset = 1'b1;
        step();
        reset = 1'b0;
        hs_low = 0; hs_bad = 0; vid_bad = 0;
        repeat (1600) begin
            step();
            if (!b_hs) hs_low++;
            if (!b_hs && (b_x < 10'd656 || b_x > 10'd751)) hs_bad++;
            if (b_vid && b_x >= 10'd640) vid_bad++;
        end
        check("hsync_low_clks", 32'(hs_low), 32'd192);
        check("hsync_outside", 32'(hs_bad), 32'd0);
        check("video_blank", 32'(vid_bad), 32'd0);

        // One full frame on the reduced geometry (15 x 8 positions, 240 clks).
        reset = 1'b1;
        step();
        reset = 1'b0;
        vs_low = 0; vs_bad = 0; ft_cnt = 0;
        repeat (240) begin
            if (s_ft) begin
                ft_cnt++;
                check("ft_position", {s_x, s_y, s_tick}, {10'd14, 10'd7, 1'b1});
            end
            step();
            if (!s_vs) vs_low++;
            if (!s_vs && (s_y < 10'd5 || s_y > 10'd6)) vs_bad++;
        end
        check("frame_wrap", {s_x, s_y}, {10'd0, 10'd0});
        check("vsync_low_clks", 32'(vs_low), 32'd60);
        check("vsync_outside", 32'(vs_bad), 32'd0);
`ifdef VGA_SYNC_FRAME_TICK_EN
        check("frame_tick_count", 32'(ft_cnt), 32'd1);
`else
        check("frame_tick_count", 32'(ft_cnt), 32'd0);
`endif

        // Random reset pulses against the arithmetic model on both instances.
        for (int i = 0; i < 20000; i++) begin
            reset = ($urandom_range(0, 399) == 0) ? 1'b1 : (reset && $urandom_range(0, 1) == 1);
            step();
            check_models("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
